// File: rtl/op_pkg.sv
// ============================================================================
// op_pkg : shared fetch/predecode types, branch opcode masks, taker helper.
// Revision 1.0
// ============================================================================
`default_nettype none

package op_pkg;

    localparam int INSTRUCTION_WIDTH  = 32;
    localparam int SUPER_SCALAR_WIDTH = 4;

    typedef struct packed {
        logic        predict_taken;
        logic [63:0] target;
    } uop_branch;

    typedef uop_branch [SUPER_SCALAR_WIDTH-1:0] branch_vec_t;

    typedef struct packed {
        logic                         valid;
        logic [63:0]                  pc;
        logic [INSTRUCTION_WIDTH-1:0] instr;
        uop_branch                    br;
    } fetch_slot_t;

    typedef fetch_slot_t [SUPER_SCALAR_WIDTH-1:0] fetch_bundle_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_L1I = 2'd1,
        S_DROP     = 2'd2
    } fetch_state_e;

    // Opcode mask/match pairs, also used by the branch predictor.
    localparam logic [31:0] C_B_MASK     = 32'hFC00_0000;
    localparam logic [31:0] C_B_MATCH    = 32'h1400_0000;
    localparam logic [31:0] C_BL_MASK    = 32'hFC00_0000;
    localparam logic [31:0] C_BL_MATCH   = 32'h9400_0000;
    localparam logic [31:0] C_RET_MASK   = 32'hFFE0_0000;
    localparam logic [31:0] C_RET_MATCH  = 32'hD640_0000;
    localparam logic [31:0] C_BCND_MASK  = 32'hFF00_0000;
    localparam logic [31:0] C_BCND_MATCH = 32'h5400_0000;

    function automatic logic is_taker(input logic [31:0] instr, input uop_branch br);
        logic uncond;
        logic cond;
        uncond = ((instr & C_B_MASK)   == C_B_MATCH)  ||
                 ((instr & C_BL_MASK)  == C_BL_MATCH) ||
                 ((instr & C_RET_MASK) == C_RET_MATCH);
        cond   = ((instr & C_BCND_MASK) == C_BCND_MATCH) && br.predict_taken;
        return uncond || cond;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_queue.sv
// ============================================================================
// fetch_queue : circular bundle buffer with wrap-bit pointers and flush.
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk_in,
    input  logic                     rst_N_in,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output T                         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;
    T            mem_q [DEPTH];

    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        full     = (count == (PW+1)'(DEPTH));
        empty    = (count == '0);
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot, so a full queue may still push.
        do_push  = push && (!full || do_pop) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q[PW-1:0]];

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : slices predicted cachelines into bundles, queues them for decode.
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import op_pkg::*;
#(
    parameter int CACHE_LINE_WIDTH   = 64,
    parameter int INSTRUCTION_WIDTH  = op_pkg::INSTRUCTION_WIDTH,
    parameter int SUPER_SCALAR_WIDTH = op_pkg::SUPER_SCALAR_WIDTH,
    parameter int FQ_DEPTH           = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_N_in,
    input  logic                          bp_pc_valid,
    input  logic [63:0]                   bp_pc,
    input  logic                          bp_l0_valid,
    input  logic [8*CACHE_LINE_WIDTH-1:0] l0_cacheline,
    input  logic                          bp_l1i_valid,
    input  logic                          l1i_valid,
    input  logic [8*CACHE_LINE_WIDTH-1:0] l1i_cacheline,
    input  branch_vec_t                   bp_branch_data,
    input  logic                          x_pc_incorrect,
    output logic                          fetch_stall,
    output logic                          dec_valid,
    input  logic                          dec_ready,
    output fetch_bundle_t                 dec_bundle
);

    localparam int WORDS = (8 * CACHE_LINE_WIDTH) / INSTRUCTION_WIDTH;
    localparam int WIW   = $clog2(WORDS);
    localparam int OFFW  = $clog2(CACHE_LINE_WIDTH);
    localparam int CW    = $clog2(FQ_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [63:0]   pend_pc_q, pend_pc_d;
    branch_vec_t   pend_br_q, pend_br_d;

    logic [63:0]                   src_pc;
    branch_vec_t                   src_br;
    logic [8*CACHE_LINE_WIDTH-1:0] src_line;
    fetch_bundle_t                 bundle;
    logic                          build_en;
    logic                          dequeue;
    logic                          q_full;
    logic                          q_empty;
    logic [CW-1:0]                 q_count;

    // In WAIT_L1I the bundle comes from the returning line and the latched PC.
    always_comb begin
        if (state_q == S_WAIT_L1I) begin
            src_pc   = pend_pc_q;
            src_br   = pend_br_q;
            src_line = l1i_cacheline;
        end else begin
            src_pc   = bp_pc;
            src_br   = bp_branch_data;
            src_line = l0_cacheline;
        end
    end

    always_comb begin
        int           base_word;
        int           word_idx;
        logic [WIW-1:0] w;
        logic         alive;
        bundle    = '0;
        alive     = 1'b1;
        base_word = int'(src_pc[OFFW-1:2]);
        for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
            word_idx         = base_word + i;
            w                = word_idx[WIW-1:0];
            bundle[i].instr  = src_line[INSTRUCTION_WIDTH*w +: INSTRUCTION_WIDTH];
            bundle[i].pc     = src_pc + 64'(4 * i);
            bundle[i].br     = src_br[i];
            bundle[i].valid  = alive && (word_idx < WORDS);
            if (bundle[i].valid && is_taker(bundle[i].instr, bundle[i].br)) alive = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        pend_br_d = pend_br_q;
        build_en  = 1'b0;
        if (x_pc_incorrect) begin
            if (state_q == S_WAIT_L1I) state_d = l1i_valid ? S_IDLE : S_DROP;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bp_pc_valid && bp_l0_valid) begin
                        build_en = 1'b1;
                    end else if (bp_pc_valid && bp_l1i_valid) begin
                        pend_pc_d = bp_pc;
                        pend_br_d = bp_branch_data;
                        state_d   = S_WAIT_L1I;
                    end
                end
                S_WAIT_L1I: begin
                    if (l1i_valid) begin
                        build_en = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (l1i_valid) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            state_q   <= S_IDLE;
            pend_pc_q <= '0;
            pend_br_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            pend_br_q <= pend_br_d;
        end
    end

    assign dec_valid = !q_empty;
    assign dequeue   = dec_valid && dec_ready;

    // Holding one slot in reserve lets a bundle built next cycle always fit.
    assign fetch_stall = (state_q != S_IDLE) ||
                         (!dequeue && (q_count >= CW'(FQ_DEPTH - 1)));

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .T     (fetch_bundle_t)
    ) u_fetch_queue (
        .clk_in    (clk_in),
        .rst_N_in  (rst_N_in),
        .push      (build_en),
        .push_data (bundle),
        .pop       (dequeue),
        .flush     (x_pc_incorrect),
        .pop_data  (dec_bundle),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    logic unused_full;
    assign unused_full = q_full;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed stimulus with a scoreboard-driven decode monitor.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;
    import op_pkg::*;

    typedef logic [8*64-1:0] line_t;

    localparam logic [31:0] NOP = 32'hD503_201F;

    logic          clk_in = 1'b0;
    logic          rst_N_in;
    logic          bp_pc_valid;
    logic [63:0]   bp_pc;
    logic          bp_l0_valid;
    line_t         l0_cacheline;
    logic          bp_l1i_valid;
    logic          l1i_valid;
    line_t         l1i_cacheline;
    branch_vec_t   bp_branch_data;
    logic          x_pc_incorrect;
    logic          fetch_stall;
    logic          dec_valid;
    logic          dec_ready;
    fetch_bundle_t dec_bundle;

    int n_vec = 0;
    int n_err = 0;
    fetch_bundle_t exp_q[$];

    fetch_unit dut (
        .clk_in         (clk_in),
        .rst_N_in       (rst_N_in),
        .bp_pc_valid    (bp_pc_valid),
        .bp_pc          (bp_pc),
        .bp_l0_valid    (bp_l0_valid),
        .l0_cacheline   (l0_cacheline),
        .bp_l1i_valid   (bp_l1i_valid),
        .l1i_valid      (l1i_valid),
        .l1i_cacheline  (l1i_cacheline),
        .bp_branch_data (bp_branch_data),
        .x_pc_incorrect (x_pc_incorrect),
        .fetch_stall    (fetch_stall),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_bundle     (dec_bundle)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic line_t fill(input logic [31:0] w);
        line_t l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = w;
        return l;
    endfunction

    function automatic line_t ramp(input logic [31:0] base);
        line_t l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    function automatic line_t put(input line_t l, input int k, input logic [31:0] w);
        line_t r;
        r = l;
        r[32*k +: 32] = w;
        return r;
    endfunction

    function automatic fetch_bundle_t mk_exp(input logic [63:0] pc, input logic [3:0] mask,
                                             input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] w2, input logic [31:0] w3,
                                             input branch_vec_t br);
        fetch_bundle_t b;
        logic [31:0] ws [4];
        ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            b[i].valid = mask[i];
            b[i].pc    = pc + 64'(4 * i);
            b[i].instr = ws[i];
            b[i].br    = br[i];
        end
        return b;
    endfunction

    // Only valid slots carry meaningful pc/instr/branch fields.
    always @(negedge clk_in) begin
        if (rst_N_in && dec_valid && dec_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL bundle_unexpected: got pc %0h, expected no bundle", dec_bundle[0].pc);
            end else begin
                fetch_bundle_t e;
                logic bad;
                e = exp_q.pop_front();
                bad = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (dec_bundle[i].valid !== e[i].valid) bad = 1'b1;
                    else if (e[i].valid && (dec_bundle[i].pc !== e[i].pc ||
                             dec_bundle[i].instr !== e[i].instr ||
                             dec_bundle[i].br !== e[i].br)) bad = 1'b1;
                end
                if (bad) begin
                    n_err++;
                    $display("FAIL bundle_pc%0h: got valid %b pc0 %0h instr %0h/%0h/%0h/%0h, expected valid %b pc0 %0h instr %0h/%0h/%0h/%0h",
                             e[0].pc,
                             {dec_bundle[3].valid, dec_bundle[2].valid, dec_bundle[1].valid, dec_bundle[0].valid},
                             dec_bundle[0].pc, dec_bundle[0].instr, dec_bundle[1].instr,
                             dec_bundle[2].instr, dec_bundle[3].instr,
                             {e[3].valid, e[2].valid, e[1].valid, e[0].valid},
                             e[0].pc, e[0].instr, e[1].instr, e[2].instr, e[3].instr);
                end
            end
        end
    end

    // The predictor must never present a PC while the fetch unit is stalling.
    always @(negedge clk_in) begin
        if (rst_N_in && bp_pc_valid && fetch_stall) begin
            n_err++;
            $display("FAIL protocol: got bp_pc_valid=1 with fetch_stall=1, expected no issue");
        end
    end

    task automatic issue_l0(input logic [63:0] pc, input line_t ln, input branch_vec_t br);
        bp_pc          = pc;
        l0_cacheline   = ln;
        bp_branch_data = br;
        bp_pc_valid    = 1'b1;
        bp_l0_valid    = 1'b1;
        tick();
        bp_pc_valid    = 1'b0;
        bp_l0_valid    = 1'b0;
    endtask

    task automatic issue_l1i(input logic [63:0] pc, input branch_vec_t br);
        bp_pc          = pc;
        bp_branch_data = br;
        bp_pc_valid    = 1'b1;
        bp_l1i_valid   = 1'b1;
        tick();
        bp_pc_valid    = 1'b0;
        bp_l1i_valid   = 1'b0;
        bp_pc          = 64'hDEAD_BEEF_0000_0000;
        bp_branch_data = '0;
    endtask

    initial begin
        line_t       ln;
        branch_vec_t br;
        branch_vec_t brz;
        brz            = '0;
        rst_N_in       = 1'b0;
        bp_pc_valid    = 1'b0;
        bp_pc          = '0;
        bp_l0_valid    = 1'b0;
        l0_cacheline   = '0;
        bp_l1i_valid   = 1'b0;
        l1i_valid      = 1'b0;
        l1i_cacheline  = '0;
        bp_branch_data = '0;
        x_pc_incorrect = 1'b0;
        dec_ready      = 1'b1;

        // Reset, with a flush also asserted to confirm reset dominates.
        repeat (2) tick();
        x_pc_incorrect = 1'b1;
        tick();
        @(negedge clk_in);
        chk("rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("rst_fetch_stall", 64'(fetch_stall), 64'd0);
        tick();
        x_pc_incorrect = 1'b0;
        rst_N_in       = 1'b1;
        tick();

        // L0 hit, full line of NOPs.
        ln = fill(NOP);
        exp_q.push_back(mk_exp(64'h1000, 4'b1111, NOP, NOP, NOP, NOP, brz));
        issue_l0(64'h1000, ln, brz);
        @(negedge clk_in);
        chk("l0_latency_dec_valid", 64'(dec_valid), 64'd1);
        tick();

        // Line-end truncation.
        ln = ramp(32'h1000_0000);
        exp_q.push_back(mk_exp(64'h1038, 4'b0011, 32'h1000_000E, 32'h1000_000F, 32'h0, 32'h0, brz));
        issue_l0(64'h1038, ln, brz);

        // B in slot 1 truncates after it.
        ln = put(fill(NOP), 1, 32'h1400_0010);
        exp_q.push_back(mk_exp(64'h1000, 4'b0011, NOP, 32'h1400_0010, NOP, NOP, brz));
        issue_l0(64'h1000, ln, brz);

        // B.cond not predicted taken does not truncate.
        ln = put(fill(NOP), 1, 32'h5400_0000);
        exp_q.push_back(mk_exp(64'h1000, 4'b1111, NOP, 32'h5400_0000, NOP, NOP, brz));
        issue_l0(64'h1000, ln, brz);

        // B.cond predicted taken truncates; branch data travels with the slots.
        br = '0;
        br[1].predict_taken = 1'b1;
        br[1].target        = 64'h1234;
        exp_q.push_back(mk_exp(64'h1000, 4'b0011, NOP, 32'h5400_0000, NOP, NOP, br));
        issue_l0(64'h1000, ln, br);

        // BL in slot 2, RET in slot 0.
        ln = put(fill(NOP), 2, 32'h9400_0001);
        exp_q.push_back(mk_exp(64'h1000, 4'b0111, NOP, NOP, 32'h9400_0001, NOP, brz));
        issue_l0(64'h1000, ln, brz);
        ln = put(fill(NOP), 0, 32'hD65F_03C0);
        exp_q.push_back(mk_exp(64'h1000, 4'b0001, 32'hD65F_03C0, NOP, NOP, NOP, brz));
        issue_l0(64'h1000, ln, brz);

        // Taker at the second slot before line end, unaligned pc[1:0].
        ln = put(ramp(32'h1000_0000), 14, 32'h1400_0000);
        exp_q.push_back(mk_exp(64'h1036, 4'b0011, 32'h1000_000D, 32'h1400_0000, 32'h0, 32'h0, brz));
        issue_l0(64'h1036, ln, brz);
        tick();

        // L1I path: five cycles of stall, bundle the cycle after the return.
        br = '0;
        br[0].target = 64'hABC;
        exp_q.push_back(mk_exp(64'h2000, 4'b1111, 32'h2000_0000, 32'h2000_0001,
                               32'h2000_0002, 32'h2000_0003, br));
        issue_l1i(64'h2000, br);
        l0_cacheline = fill(32'h1400_0000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            chk("l1i_wait_stall", 64'(fetch_stall), 64'd1);
            tick();
        end
        l1i_valid     = 1'b1;
        l1i_cacheline = ramp(32'h2000_0000);
        @(negedge clk_in);
        chk("l1i_return_stall", 64'(fetch_stall), 64'd1);
        tick();
        l1i_valid = 1'b0;
        @(negedge clk_in);
        chk("l1i_latency_dec_valid", 64'(dec_valid), 64'd1);
        chk("l1i_done_stall", 64'(fetch_stall), 64'd0);
        tick();

        // Flush while waiting; the stale return must be dropped.
        issue_l1i(64'h3000, brz);
        tick();
        x_pc_incorrect = 1'b1;
        tick();
        x_pc_incorrect = 1'b0;
        @(negedge clk_in);
        chk("drop_stall", 64'(fetch_stall), 64'd1);
        chk("drop_dec_valid", 64'(dec_valid), 64'd0);
        tick();
        tick();
        l1i_valid     = 1'b1;
        l1i_cacheline = fill(NOP);
        tick();
        l1i_valid = 1'b0;
        @(negedge clk_in);
        chk("stale_dropped_dec_valid", 64'(dec_valid), 64'd0);
        chk("drop_exit_stall", 64'(fetch_stall), 64'd0);
        tick();
        exp_q.push_back(mk_exp(64'h4000, 4'b1111, NOP, NOP, NOP, NOP, brz));
        issue_l0(64'h4000, fill(NOP), brz);
        @(negedge clk_in);
        chk("post_flush_dec_valid", 64'(dec_valid), 64'd1);
        tick();

        // Flush empties queued bundles and suppresses a same-cycle enqueue.
        dec_ready = 1'b0;
        issue_l0(64'h6000, fill(NOP), brz);
        issue_l0(64'h6040, fill(NOP), brz);
        @(negedge clk_in);
        chk("preflush_dec_valid", 64'(dec_valid), 64'd1);
        tick();
        x_pc_incorrect = 1'b1;
        issue_l0(64'h6080, fill(NOP), brz);
        x_pc_incorrect = 1'b0;
        @(negedge clk_in);
        chk("flush_empty_dec_valid", 64'(dec_valid), 64'd0);
        chk("flush_empty_stall", 64'(fetch_stall), 64'd0);
        tick();

        // Back-pressure: stall rises with three held bundles, then drain in order.
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk_exp(64'h5000 + 64'(64 * k), 4'b1111,
                                   32'h0B00_0000 + 32'(k), 32'h0B00_0000 + 32'(k),
                                   32'h0B00_0000 + 32'(k), 32'h0B00_0000 + 32'(k), brz));
            issue_l0(64'h5000 + 64'(64 * k), fill(32'h0B00_0000 + 32'(k)), brz);
            @(negedge clk_in);
            chk("bp_stall", 64'(fetch_stall), (k == 2) ? 64'd1 : 64'd0);
            tick();
        end
        chk("bp_held_dec_valid", 64'(dec_valid), 64'd1);
        dec_ready = 1'b1;
        @(negedge clk_in);
        chk("bp_release_stall", 64'(fetch_stall), 64'd0);
        tick();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        @(negedge clk_in);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        chk("final_dec_valid", 64'(dec_valid), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
